opt_delta_seq: RTL

Computes the signed tour-length change for one candidate move of a replica's city ordering: 2-opt, or-opt (both directions), or a two-city swap. It sits between the replica's move generator and the Metropolis accept logic. It sequences position-pair lookups into an external distance datapath with fixed latency and accumulates the terms. It generalises the fixed 30-city, 18-bit distance arithmetic to parametrised city count, distance width and lookup latency, and adds the swap mode on the THR opcode.

---
 rtl/opt_delta_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/opt_delta_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | opt_delta_seq: sequences distance lookups for one candidate tour move     |
// |   (2-opt, or-opt, swap) and accumulates the signed length change.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module opt_delta_seq #(
  parameter int CITY_NUM = 30,
  parameter int DIST_W   = 18,
  parameter int LAT      = 1,
  parameter int CITY_W   = $clog2(CITY_NUM),
  parameter int DELTA_W  = DIST_W + 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         cmd,
  input  logic [CITY_W-1:0]  k,
  input  logic [CITY_W-1:0]  l,
  output logic               dist_req,
  output logic [CITY_W-1:0]  dist_a,
  output logic [CITY_W-1:0]  dist_b,
  input  logic [DIST_W-1:0]  dist_data,
  output logic               done_valid,
  input  logic               done_ready,
  output logic [DELTA_W-1:0] delta,
  output logic               err
);

  localparam logic [1:0] c_CMD_THR = 2'd0;
  localparam logic [1:0] c_CMD_TWO = 2'd1;
  localparam logic [1:0] c_CMD_OR0 = 2'd2;
  localparam logic [1:0] c_CMD_OR1 = 2'd3;

  localparam logic [CITY_W-1:0] c_LAST = CITY_W'(CITY_NUM - 1);
  localparam logic [CITY_W-1:0] c_ONE  = CITY_W'(1);
  // All tag stages except the output stage; DRAIN ends once these are empty.
  localparam logic [LAT-1:0]    c_LOWER = {LAT{1'b1}} >> 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_cmd;
  logic [CITY_W-1:0]    r_k;
  logic [CITY_W-1:0]    r_l;
  logic [2:0]           r_cnt;
  logic [DELTA_W-1:0]   r_acc;
  logic                 r_err;
  logic [LAT-1:0]       r_vld;
  logic [LAT-1:0]       r_sgn;

  logic                 w_illegal;
  logic                 w_req;
  logic                 w_neg;
  logic [2:0]           w_last_idx;
  logic [CITY_W-1:0]    w_a;
  logic [CITY_W-1:0]    w_b;
  logic [CITY_W-1:0]    w_kp;
  logic [CITY_W-1:0]    w_km;
  logic [CITY_W-1:0]    w_lp;
  logic [CITY_W-1:0]    w_lm;
  logic [DELTA_W-1:0]   w_term;

  always_comb begin
    w_illegal = 1'b0;
    if (int'(k) >= CITY_NUM || int'(l) >= CITY_NUM) begin
      w_illegal = 1'b1;
    end else begin
      case (cmd)
        c_CMD_TWO, c_CMD_OR0: w_illegal = !(int'(k) < int'(l));
        c_CMD_OR1:            w_illegal = !(int'(k) > int'(l) + 1);
        default:              w_illegal = (int'(l) < int'(k) + 2) ||
                                          (k == '0 && l == c_LAST);
      endcase
    end
  end

  assign w_kp = (r_k == c_LAST) ? '0 : r_k + c_ONE;
  assign w_km = (r_k == '0) ? c_LAST : r_k - c_ONE;
  assign w_lp = (r_l == c_LAST) ? '0 : r_l + c_ONE;
  assign w_lm = (r_l == '0) ? c_LAST : r_l - c_ONE;

  always_comb begin
    w_a        = '0;
    w_b        = '0;
    w_neg      = 1'b0;
    w_last_idx = 3'd7;
    case (r_cmd)
      c_CMD_TWO: begin
        w_last_idx = 3'd3;
        w_neg      = (r_cnt >= 3'd2);
        case (r_cnt)
          3'd0:    begin w_a = r_k;  w_b = r_l;  end
          3'd1:    begin w_a = w_kp; w_b = w_lp; end
          3'd2:    begin w_a = r_k;  w_b = w_kp; end
          default: begin w_a = r_l;  w_b = w_lp; end
        endcase
      end
      c_CMD_OR0, c_CMD_OR1: begin
        w_last_idx = 3'd5;
        w_neg      = (r_cnt >= 3'd3);
        case (r_cnt)
          3'd0:    begin w_a = w_km; w_b = w_kp; end
          3'd1:    begin w_a = r_l;  w_b = r_k;  end
          3'd2:    begin w_a = r_k;  w_b = w_lp; end
          3'd3:    begin w_a = w_km; w_b = r_k;  end
          3'd4:    begin w_a = r_k;  w_b = w_kp; end
          default: begin w_a = r_l;  w_b = w_lp; end
        endcase
      end
      default: begin
        w_last_idx = 3'd7;
        w_neg      = (r_cnt >= 3'd4);
        case (r_cnt)
          3'd0:    begin w_a = w_km; w_b = r_l;  end
          3'd1:    begin w_a = r_l;  w_b = w_kp; end
          3'd2:    begin w_a = w_lm; w_b = r_k;  end
          3'd3:    begin w_a = r_k;  w_b = w_lp; end
          3'd4:    begin w_a = w_km; w_b = r_k;  end
          3'd5:    begin w_a = r_k;  w_b = w_kp; end
          3'd6:    begin w_a = w_lm; w_b = r_l;  end
          default: begin w_a = r_l;  w_b = w_lp; end
        endcase
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_state_nxt = w_illegal ? S_DONE : S_ISSUE;
      S_ISSUE: if (r_cnt == w_last_idx) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_vld & c_LOWER) == '0) w_state_nxt = S_DONE;
      default: if (done_ready) w_state_nxt = S_IDLE;
    endcase
  end

  assign w_req  = (r_state == S_ISSUE);
  assign w_term = {{(DELTA_W - DIST_W){1'b0}}, dist_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_k     <= '0;
      r_l     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
      r_vld   <= '0;
      r_sgn   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld[0] <= w_req;
      r_sgn[0] <= w_neg;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_sgn[i] <= r_sgn[i-1];
      end
      if (r_state == S_IDLE && start_valid) begin
        r_cmd <= cmd;
        r_k   <= k;
        r_l   <= l;
        r_cnt <= '0;
        r_acc <= '0;
        r_err <= w_illegal;
      end else begin
        if (r_state == S_ISSUE) r_cnt <= r_cnt + 3'd1;
        if (r_vld[LAT-1]) r_acc <= r_sgn[LAT-1] ? r_acc - w_term : r_acc + w_term;
      end
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign dist_req    = w_req;
  assign dist_a      = w_req ? w_a : '0;
  assign dist_b      = w_req ? w_b : '0;
  assign done_valid  = (r_state == S_DONE);
  assign delta       = r_acc;
  assign err         = r_err;

endmodule
`default_nettype wire
